mux_sel_arbiter: RTL and testbench
==================================

# mux_sel_arbiter

Four-channel round-robin arbiter that drives the dual-rail select pair (`Select` / `_Select`) of the 1-bit 4:1 mux datapath stage directly downstream. It grants one of four requesters at a time and drives the mux select for that requester's index. Between grants it inserts one settling cycle, so the mux output has stabilised before `Valid` and `Grant` assert. `_Select` is always the exact complement of `Select`, so the downstream mux never sees an illegal rail combination.

## Interface
- `HOLD_MAX`, default 8: maximum consecutive cycles one requester may hold a grant. Must be ≥ 1.
- `CNT_W`, default 4: width of the hold counter. Must satisfy 2^CNT_W > HOLD_MAX.
- `Clock`  in  1  single clock; all state changes on the rising edge.
- `_Reset`  in  1  asynchronous, active-low reset.
- `Req`  in  4  request per channel; level-sensitive, held high while the requester wants the mux.
- `Select`  out  2  true-rail mux select; binary index of the selected channel.
- `_Select`  out  2  complement-rail mux select; always `~Select`.
- `Grant`  out  4  one-hot grant; all zero when no grant is active.
- `Valid`  out  1  high when the mux output reflects the granted channel.

## Operation
- **Reset values** (immediate on `_Reset` low, independent of `Clock`):
  - `Select` = 00, `_Select` = 11
  - `Grant` = 0000, `Valid` = 0
  - state = IDLE, round-robin pointer = 0, hold counter = 0
- **States:** IDLE, SWITCH, GRANT. All outputs are registered.
- **Winner search:** the first index i with `Req[i]` = 1, scanning `pointer`, `pointer+1`, … mod 4.
- **IDLE:**
  - If any `Req` bit is high, load `Select` with the winner index (`_Select` = its complement) and go to SWITCH.
  - Otherwise stay in IDLE. `Select` keeps its last value.
- **SWITCH:** one cycle with `Valid` = 0 and `Grant` = 0000. Then go to GRANT unconditionally:
  - `Grant[Select]` = 1, `Valid` = 1, hold counter = 1.
  - The winner is committed even if its `Req` drops during SWITCH; it then releases after one GRANT cycle.
- **GRANT:** at each edge, evaluate `release = ~Req[Select] | (hold counter == HOLD_MAX)`.
  - No release: increment the hold counter. `Grant`, `Valid` and `Select` are unchanged.
  - Release: set pointer = `Select`+1 mod 4, clear `Grant` and `Valid`, clear the hold counter, then run the winner search with the new pointer and current `Req`.
    - Hit: load `Select` and go to SWITCH.
    - No hit: go to IDLE.
  - The current holder is searched last, so a lone requester whose hold limit expired is re-granted after a SWITCH cycle.
- **Invariants, checked every cycle:**
  - `_Select` == `~Select`.
  - `Grant` is zero or one-hot.
  - `Valid` == |`Grant`.
  - When `Valid` = 1, `Grant[Select]` = 1.
  - `Select` changes only on an edge that enters SWITCH.
- **Reset mid-operation:** any state returns immediately to reset values. The pointer returns to 0, so the next search starts at channel 0.

## Timing
- **Grant latency from IDLE:** `Req` sampled high at edge n → `Select` valid after n; `Grant` and `Valid` high after n+1. Two edges total.
- **Handover:** release decided at edge m → `Grant` low and new `Select` after m; new `Grant` high after m+1. Exactly one dead cycle between grants.
- **Maximum continuous hold:** `HOLD_MAX` cycles with `Grant` high.
- **Worst-case wait for a continuously requesting channel:** 3·(`HOLD_MAX`+1) cycles after it becomes eligible.
- **Release on `Req` drop:** `Req[Select]` sampled low at edge m → `Grant` low after m. There is no combinational path from `Req` to any output.

## Test plan
- **Reset:** `_Reset` low mid-cycle with `Clock` stopped → immediately `Select`=00, `_Select`=11, `Grant`=0000, `Valid`=0. Release reset with `Req`=0000 → outputs hold for 10 cycles.
- **Single request:** only `Req[2]` raised → after 1 edge `Select`=10, `_Select`=01, `Valid`=0. After 2 edges `Grant`=0100, `Valid`=1. Drop `Req[2]` → `Grant`=0000 after the next edge, state IDLE, `Select` stays 10.
- **Full load:** `Req`=1111 held, `HOLD_MAX`=8 → grant sequence 0,1,2,3,0. Each grant high for exactly 8 cycles with one `Valid`=0 cycle between.
- **Fairness:** `Req`=1010 held, `HOLD_MAX`=3 → grants alternate 1,3,1,3. Channels 0 and 2 are never granted.
- **Expiry with lone requester:** `Req[0]` held alone, `HOLD_MAX`=2 → `Grant` pattern 0001, 0001, 0000 repeating. `Select` stays 00.
- **Reset mid-grant:** reset asserted while channel 3 is granted → outputs return to reset values at once. Release reset with `Req`=1010 → channel 1 is granted first (pointer 0). `_Select`==`~Select` is asserted every cycle throughout.

Source files
------------

// File: rtl/mux_sel_arbiter.sv
// mux_sel_arbiter
//   Four-channel round-robin arbiter driving the dual-rail select pair of the
//   downstream 1-bit 4:1 mux. A new selection always spends one SWITCH cycle
//   with Grant/Valid low so the mux output settles before it is advertised.
//
// Parameters
//   HOLD_MAX : maximum consecutive Grant cycles for one requester (>= 1)
//   CNT_W    : hold counter width, 2**CNT_W must exceed HOLD_MAX
//
// Ports
//   Clock    in   rising-edge clock
//   _Reset   in   asynchronous active-low reset
//   Req      in   [3:0] level-sensitive request per channel
//   Select   out  [1:0] true-rail mux select (binary channel index)
//   _Select  out  [1:0] complement-rail mux select, always ~Select
//   Grant    out  [3:0] one-hot grant, zero when idle or switching
//   Valid    out  high while the mux output reflects the granted channel
module mux_sel_arbiter #(
    parameter int unsigned HOLD_MAX = 8,
    parameter int unsigned CNT_W    = 4
) (
    input  logic       Clock,
    input  logic       _Reset,
    input  logic [3:0] Req,
    output logic [1:0] Select,
    output logic [1:0] _Select,
    output logic [3:0] Grant,
    output logic       Valid
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SWITCH = 2'd1;
    localparam logic [1:0] GRANT  = 2'd2;

    localparam logic [CNT_W-1:0] HOLD_LIMIT = CNT_W'(HOLD_MAX);
    localparam logic [CNT_W-1:0] HOLD_ONE   = CNT_W'(1);

    logic [1:0]       state;
    logic [1:0]       pointer;
    logic [CNT_W-1:0] hold_cnt;

    logic [1:0] search_ptr;
    logic       win_hit;
    logic [1:0] win_idx;
    logic       release_now;

    // On a release the pointer update and the search happen on the same edge,
    // so the search must already use Select+1 rather than the stale pointer.
    // That places the current holder last in the scan order.
    always_comb begin
        search_ptr = pointer;
        if (state == GRANT) begin
            search_ptr = Select + 2'd1;
        end
    end

    always_comb begin
        win_hit = 1'b0;
        win_idx = search_ptr;
        for (int unsigned i = 0; i < 4; i++) begin
            if (!win_hit && Req[search_ptr + 2'(i)]) begin
                win_hit = 1'b1;
                win_idx = search_ptr + 2'(i);
            end
        end
    end

    assign release_now = ~Req[Select] | (hold_cnt == HOLD_LIMIT);

    always_ff @(posedge Clock or negedge _Reset) begin
        if (!_Reset) begin
            state    <= IDLE;
            pointer  <= '0;
            hold_cnt <= '0;
            Select   <= '0;
            _Select  <= '1;
            Grant    <= '0;
            Valid    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_hit) begin
                        Select  <= win_idx;
                        _Select <= ~win_idx;
                        state   <= SWITCH;
                    end
                end

                // The winner is committed here regardless of its current Req;
                // if it has already dropped it is released after one cycle.
                SWITCH: begin
                    Grant    <= 4'b0001 << Select;
                    Valid    <= 1'b1;
                    hold_cnt <= HOLD_ONE;
                    state    <= GRANT;
                end

                GRANT: begin
                    if (!release_now) begin
                        hold_cnt <= hold_cnt + HOLD_ONE;
                    end else begin
                        pointer  <= Select + 2'd1;
                        Grant    <= '0;
                        Valid    <= 1'b0;
                        hold_cnt <= '0;
                        if (win_hit) begin
                            Select  <= win_idx;
                            _Select <= ~win_idx;
                            state   <= SWITCH;
                        end else begin
                            state   <= IDLE;
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Output invariants the downstream mux relies on.
    a_rail_complement : assert property (@(posedge Clock) disable iff (!_Reset)
        _Select == ~Select);
    a_grant_onehot : assert property (@(posedge Clock) disable iff (!_Reset)
        $onehot0(Grant));
    a_valid_grant : assert property (@(posedge Clock) disable iff (!_Reset)
        Valid == (|Grant));
    a_grant_selected : assert property (@(posedge Clock) disable iff (!_Reset)
        Valid |-> Grant[Select]);

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// tb_mux_sel_arbiter
//   Directed bench for mux_sel_arbiter. Three instances share clock and reset:
//   dut_a (HOLD_MAX=8), dut_b (HOLD_MAX=3), dut_c (HOLD_MAX=2). Inputs are
//   driven 1 time unit after the rising edge; output invariants are sampled
//   on the falling edge.
module tb_mux_sel_arbiter;

    logic       clk;
    logic       clk_en;
    logic       rst_n;
    logic [3:0] req   [3];
    logic [1:0] sel   [3];
    logic [1:0] sel_n [3];
    logic [3:0] grant [3];
    logic       valid [3];

    int n_checks;
    int n_fail;
    logic       mon_en;
    logic [1:0] prev_sel [3];

    mux_sel_arbiter #(.HOLD_MAX(8), .CNT_W(4)) dut_a (
        .Clock(clk), ._Reset(rst_n), .Req(req[0]),
        .Select(sel[0]), ._Select(sel_n[0]), .Grant(grant[0]), .Valid(valid[0])
    );

    mux_sel_arbiter #(.HOLD_MAX(3), .CNT_W(4)) dut_b (
        .Clock(clk), ._Reset(rst_n), .Req(req[1]),
        .Select(sel[1]), ._Select(sel_n[1]), .Grant(grant[1]), .Valid(valid[1])
    );

    mux_sel_arbiter #(.HOLD_MAX(2), .CNT_W(4)) dut_c (
        .Clock(clk), ._Reset(rst_n), .Req(req[2]),
        .Select(sel[2]), ._Select(sel_n[2]), .Grant(grant[2]), .Valid(valid[2])
    );

    initial clk = 1'b0;
    always #5 if (clk_en) clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic check_out(input string tag, input int k, input logic [1:0] es,
                             input logic [3:0] eg, input logic ev);
        logic [1:0] es_n;
        es_n = ~es;
        check({tag, "_sel"},   {30'b0, sel[k]},   {30'b0, es});
        check({tag, "_seln"},  {30'b0, sel_n[k]}, {30'b0, es_n});
        check({tag, "_grant"}, {28'b0, grant[k]}, {28'b0, eg});
        check({tag, "_valid"}, {31'b0, valid[k]}, {31'b0, ev});
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse;
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
    endtask

    // Invariant monitor on the falling edge.
    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            for (int k = 0; k < 3; k++) begin
                logic [1:0] inv_sel;
                inv_sel = ~sel[k];
                check("inv_rail", {30'b0, sel_n[k]}, {30'b0, inv_sel});
                check("inv_onehot", {31'b0, $onehot0(grant[k])}, 32'd1);
                check("inv_valid", {31'b0, valid[k]}, {31'b0, |grant[k]});
                if (valid[k]) begin
                    check("inv_gsel", {31'b0, grant[k][sel[k]]}, 32'd1);
                end
                // A Select change is only legal on entry to SWITCH, where
                // Grant and Valid are low.
                if (sel[k] != prev_sel[k]) begin
                    check("inv_selchg", {27'b0, grant[k], valid[k]}, 32'd0);
                end
                prev_sel[k] = sel[k];
            end
        end
    end

    always @(negedge rst_n) begin
        for (int k = 0; k < 3; k++) prev_sel[k] = 2'b00;
    end

    initial begin
        int seq_full [5];
        int seq_fair [4];
        logic [1:0] es;
        logic [3:0] eg;

        n_checks = 0;
        n_fail   = 0;
        mon_en   = 1'b0;
        clk_en   = 1'b0;
        rst_n    = 1'b1;
        for (int k = 0; k < 3; k++) begin
            req[k]      = 4'b0000;
            prev_sel[k] = 2'b00;
        end

        // Reset with the clock stopped: outputs must settle immediately.
        #3 rst_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) check_out("rst_async", k, 2'b00, 4'b0000, 1'b0);
        mon_en = 1'b1;
        clk_en = 1'b1;
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (10) begin
            tick();
            for (int k = 0; k < 3; k++) check_out("rst_hold", k, 2'b00, 4'b0000, 1'b0);
        end

        // Single request on channel 2.
        reset_pulse();
        req[0] = 4'b0100;
        tick();
        check_out("single_sw", 0, 2'b10, 4'b0000, 1'b0);
        tick();
        check_out("single_gnt", 0, 2'b10, 4'b0100, 1'b1);
        req[0] = 4'b0000;
        tick();
        check_out("single_rel", 0, 2'b10, 4'b0000, 1'b0);
        repeat (3) begin
            tick();
            check_out("single_idle", 0, 2'b10, 4'b0000, 1'b0);
        end

        // Full load, HOLD_MAX=8: 0,1,2,3,0 with 8 grant cycles and one gap.
        reset_pulse();
        seq_full = '{0, 1, 2, 3, 0};
        req[0] = 4'b1111;
        tick();
        check_out("full_sw0", 0, 2'b00, 4'b0000, 1'b0);
        for (int i = 0; i < 5; i++) begin
            es = 2'(seq_full[i]);
            eg = 4'b0001 << es;
            repeat (8) begin
                tick();
                check_out("full_gnt", 0, es, eg, 1'b1);
            end
            es = es + 2'd1;
            tick();
            check_out("full_gap", 0, es, 4'b0000, 1'b0);
        end
        req[0] = 4'b0000;

        // Fairness, HOLD_MAX=3, Req=1010: grants alternate 1,3,1,3.
        reset_pulse();
        seq_fair = '{1, 3, 1, 3};
        req[1] = 4'b1010;
        tick();
        check_out("fair_sw0", 1, 2'b01, 4'b0000, 1'b0);
        for (int i = 0; i < 4; i++) begin
            es = 2'(seq_fair[i]);
            eg = 4'b0001 << es;
            repeat (3) begin
                tick();
                check_out("fair_gnt", 1, es, eg, 1'b1);
            end
            es = (seq_fair[i] == 1) ? 2'd3 : 2'd1;
            tick();
            check_out("fair_gap", 1, es, 4'b0000, 1'b0);
        end
        req[1] = 4'b0000;

        // Lone requester hitting the hold limit, HOLD_MAX=2.
        reset_pulse();
        req[2] = 4'b0001;
        tick();
        check_out("exp_sw0", 2, 2'b00, 4'b0000, 1'b0);
        repeat (3) begin
            repeat (2) begin
                tick();
                check_out("exp_gnt", 2, 2'b00, 4'b0001, 1'b1);
            end
            tick();
            check_out("exp_gap", 2, 2'b00, 4'b0000, 1'b0);
        end
        req[2] = 4'b0000;

        // Reset while channel 3 holds the grant; pointer restarts at 0.
        reset_pulse();
        req[0] = 4'b1000;
        tick();
        check_out("mid_sw", 0, 2'b11, 4'b0000, 1'b0);
        tick();
        check_out("mid_gnt", 0, 2'b11, 4'b1000, 1'b1);
        tick();
        check_out("mid_gnt2", 0, 2'b11, 4'b1000, 1'b1);
        rst_n = 1'b0;
        #1;
        check_out("mid_rst", 0, 2'b00, 4'b0000, 1'b0);
        req[0] = 4'b1010;
        #1 rst_n = 1'b1;
        tick();
        check_out("mid_after_sw", 0, 2'b01, 4'b0000, 1'b0);
        tick();
        check_out("mid_after_gnt", 0, 2'b01, 4'b0010, 1'b1);
        req[0] = 4'b0000;
        repeat (3) tick();

        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
